flash_arbiter: RTL

- Shares the single 8-bit parallel flash between two 16-bit word requesters:
  - audio sample fetch (the reader/playback path);
  - cover-art fetch (the VGA colour path).
- Owns all FL_* pins.
- Performs two byte reads per word, applying programmable access wait states.
- Audio has fixed priority. A starvation limit guarantees that cover art still makes progress.

---
 rtl/flash_arb_pkg.sv | 10 +
 rtl/flash_byte_timer.sv | 29 ++
 rtl/flash_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-requester flash arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} arb_state_t;
  typedef enum logic {OWN_AUD, OWN_ART} owner_t;

  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;

endpackage

// File: rtl/flash_byte_timer.sv
// Loadable down-counter that times how long each byte address is held on the flash.
module flash_byte_timer #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic load,
  input  logic start,
  output logic zero
);

  // A single-cycle wait still needs a 1-bit counter.
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (Reset)
      count <= '0;
    else if (load)
      count <= LOAD_VAL;
    else if (start && (count != '0))
      count <= count - CW'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/flash_arbiter.sv
// Shares the 8-bit flash between audio and cover-art word fetches (audio priority, starvation limit).
// Optional per-requester word counters are enabled by defining FLASH_ARB_STATS_EN.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int STARVE_MAX  = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        aud_req,
  input  logic [21:0] aud_addr,
  output logic        aud_gnt,
  output logic        aud_valid,
  output logic [15:0] aud_data,
  input  logic        art_req,
  input  logic [21:0] art_addr,
  output logic        art_gnt,
  output logic        art_valid,
  output logic [15:0] art_data,
  output logic [22:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        FL_OE_N,
  output logic        FL_CE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N,
  output logic        busy
`ifdef FLASH_ARB_STATS_EN
  ,
  output logic [15:0] stat_aud_words,
  output logic [15:0] stat_art_words
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t    state, state_nxt;
  owner_t        owner;
  logic [21:0]   cur_addr;
  logic [21:0]   win_addr;
  logic [7:0]    lo_byte;
  logic [SW-1:0] starve_cnt;
  logic          grant_any, pick_art;
  logic          timer_load, timer_start, timer_zero;
  logic          fl_active;

  flash_byte_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk   (clk),
    .Reset (Reset),
    .load  (timer_load),
    .start (timer_start),
    .zero  (timer_zero)
  );

  // Grants are combinational so the requester sees gnt in the same cycle its address is captured.
  always_comb begin
    state_nxt = state;
    grant_any = 1'b0;
    pick_art  = 1'b0;
    aud_gnt   = 1'b0;
    art_gnt   = 1'b0;
    case (state)
      IDLE: begin
        if (!Reset && (aud_req || art_req)) begin
          grant_any = 1'b1;
          pick_art  = art_req && (!aud_req || (starve_cnt == STARVE_LIM));
          aud_gnt   = !pick_art;
          art_gnt   = pick_art;
          state_nxt = LOW;
        end
      end
      LOW:     if (timer_zero) state_nxt = HIGH;
      HIGH:    if (timer_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign win_addr    = pick_art ? art_addr : aud_addr;
  assign timer_load  = grant_any || ((state == LOW) && timer_zero);
  assign timer_start = (state == LOW) || (state == HIGH);

  // Data and valid are registered on the last HIGH cycle, so both are present together in DONE.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      owner      <= OWN_AUD;
      cur_addr   <= '0;
      lo_byte    <= '0;
      FL_ADDR    <= '0;
      aud_data   <= '0;
      art_data   <= '0;
      aud_valid  <= 1'b0;
      art_valid  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state     <= state_nxt;
      aud_valid <= 1'b0;
      art_valid <= 1'b0;
      if (grant_any) begin
        owner    <= pick_art ? OWN_ART : OWN_AUD;
        cur_addr <= win_addr;
        FL_ADDR  <= {win_addr, BYTE_LO};
      end
      if ((state == LOW) && timer_zero) begin
        lo_byte <= FL_DQ;
        FL_ADDR <= {cur_addr, BYTE_HI};
      end
      if ((state == HIGH) && timer_zero) begin
        if (owner == OWN_AUD) begin
          aud_data  <= {FL_DQ, lo_byte};
          aud_valid <= 1'b1;
        end else begin
          art_data  <= {FL_DQ, lo_byte};
          art_valid <= 1'b1;
        end
      end
      if (!art_req || art_gnt)
        starve_cnt <= '0;
      else if (aud_gnt && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign fl_active = !Reset && ((state == LOW) || (state == HIGH));
  assign FL_CE_N   = !fl_active;
  assign FL_OE_N   = !fl_active;
  assign FL_WE_N   = 1'b1;
  assign FL_RST_N  = !Reset;
  assign busy      = (state != IDLE);

`ifdef FLASH_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      stat_aud_words <= '0;
      stat_art_words <= '0;
    end else begin
      if (aud_valid) stat_aud_words <= stat_aud_words + 16'd1;
      if (art_valid) stat_art_words <= stat_art_words + 16'd1;
    end
  end
`endif

endmodule
